// File: rtl/vis_pkg.sv
// Shared types and constants for the multi-box video overlay.
package vis_pkg;

  localparam int COORD_W = 11;
  localparam int PIX_W   = 24;
  // Hit arithmetic runs one bit wider than coordinates so x+LINE_W cannot wrap.
  localparam int CMP_W   = COORD_W + 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // One video beat: sync/enable flags plus the {R,G,B} pixel.
  typedef struct packed {
    logic             de;
    logic             hsync;
    logic             vsync;
    logic [PIX_W-1:0] pix;
  } vid_t;

  localparam logic [PIX_W-1:0] RED   = 24'hFF0000;
  localparam logic [PIX_W-1:0] GREEN = 24'h00FF00;
  localparam logic [PIX_W-1:0] BLUE  = 24'h0000FF;
  localparam logic [PIX_W-1:0] WHITE = 24'hFFFFFF;
  localparam logic [PIX_W-1:0] BLACK = 24'h000000;

endpackage

// File: rtl/vis_box_hit.sv
// Combinational hit test of one pixel position against one shadowed box.
module vis_box_hit
  import vis_pkg::*;
#(
  parameter int LINE_W = 2
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  input  logic               i_en,
  input  logic               i_fill,
  output logic               o_hit
);

  localparam logic [CMP_W-1:0] LW = CMP_W'(LINE_W);

  logic [CMP_W-1:0] w_x, w_y, w_x0, w_y0, w_x1, w_y1;
  logic             w_valid, w_inside, w_edge;

  assign w_x  = {1'b0, i_x};
  assign w_y  = {1'b0, i_y};
  assign w_x0 = {1'b0, i_x0};
  assign w_y0 = {1'b0, i_y0};
  assign w_x1 = {1'b0, i_x1};
  assign w_y1 = {1'b0, i_y1};

  // Degenerate (inverted) boxes never draw.
  assign w_valid  = (w_x0 <= w_x1) && (w_y0 <= w_y1);
  assign w_inside = (w_x0 <= w_x) && (w_x <= w_x1) && (w_y0 <= w_y) && (w_y <= w_y1);
  // Outline band lies inside the box; a box thinner than two bands is all band.
  assign w_edge   = (w_x < w_x0 + LW) || (w_x + LW > w_x1) ||
                    (w_y < w_y0 + LW) || (w_y + LW > w_y1);

  assign o_hit = i_en && w_valid && w_inside && (i_fill || w_edge);

endmodule

// File: rtl/vis_multi_box_overlay.sv
// Multi-box overlay: frame-latched box shadows, position counters,
// per-box hit test (stage 1) and lowest-index priority select (stage 2).
// Stream handshake: there is no back-pressure; every clock carries one beat,
// de marks active pixels, and all outputs are the inputs delayed by 2 clocks.
module vis_multi_box_overlay
  import vis_pkg::*;
#(
  parameter int IMG_W     = 1280,
  parameter int IMG_H     = 720,
  parameter int NUM_BOXES = 4,
  parameter int LINE_W    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         de_in,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic [PIX_W-1:0]             pixel_in,
  input  logic [COORD_W*NUM_BOXES-1:0] box_x0,
  input  logic [COORD_W*NUM_BOXES-1:0] box_y0,
  input  logic [COORD_W*NUM_BOXES-1:0] box_x1,
  input  logic [COORD_W*NUM_BOXES-1:0] box_y1,
  input  logic [PIX_W*NUM_BOXES-1:0]   box_color,
  input  logic [NUM_BOXES-1:0]         box_en,
  input  logic [NUM_BOXES-1:0]         box_fill,
  output logic                         de_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic [PIX_W-1:0]             pixel_out
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

  state_t               r_state, w_state_next;
  logic                 r_vsync_q;
  logic                 w_vs_rise;
  logic [COORD_W-1:0]   r_x, r_y;

  logic [COORD_W-1:0]   r_sh_x0 [NUM_BOXES];
  logic [COORD_W-1:0]   r_sh_y0 [NUM_BOXES];
  logic [COORD_W-1:0]   r_sh_x1 [NUM_BOXES];
  logic [COORD_W-1:0]   r_sh_y1 [NUM_BOXES];
  logic [PIX_W-1:0]     r_sh_color [NUM_BOXES];
  logic [NUM_BOXES-1:0] r_sh_en, r_sh_fill;

  logic [NUM_BOXES-1:0] w_hit, r_hit;
  vid_t                 r_s1, r_s2;
  logic                 w_any_hit;
  logic [PIX_W-1:0]     w_sel_color;

  assign w_vs_rise = vsync_in & ~r_vsync_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next state: overlay becomes active on the first frame start, then stays.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_IDLE && w_vs_rise) w_state_next = ST_ACTIVE;
  end

  // Position counters: cleared during vsync, advance on each active pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_q <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_vsync_q <= vsync_in;
      if (vsync_in) begin
        r_x <= '0;
        r_y <= '0;
      end else if (de_in) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  // Shadow box set, captured only at frame start so host writes never tear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_BOXES; k++) begin
        r_sh_x0[k]    <= '0;
        r_sh_y0[k]    <= '0;
        r_sh_x1[k]    <= '0;
        r_sh_y1[k]    <= '0;
        r_sh_color[k] <= '0;
      end
      r_sh_en   <= '0;
      r_sh_fill <= '0;
    end else if (w_vs_rise) begin
      for (int k = 0; k < NUM_BOXES; k++) begin
        r_sh_x0[k]    <= box_x0[COORD_W*k +: COORD_W];
        r_sh_y0[k]    <= box_y0[COORD_W*k +: COORD_W];
        r_sh_x1[k]    <= box_x1[COORD_W*k +: COORD_W];
        r_sh_y1[k]    <= box_y1[COORD_W*k +: COORD_W];
        r_sh_color[k] <= box_color[PIX_W*k +: PIX_W];
      end
      r_sh_en   <= box_en;
      r_sh_fill <= box_fill;
    end
  end

  for (genvar k = 0; k < NUM_BOXES; k++) begin : g_hit
    vis_box_hit #(.LINE_W(LINE_W)) u_hit (
      .i_x    (r_x),
      .i_y    (r_y),
      .i_x0   (r_sh_x0[k]),
      .i_y0   (r_sh_y0[k]),
      .i_x1   (r_sh_x1[k]),
      .i_y1   (r_sh_y1[k]),
      .i_en   (r_sh_en[k]),
      .i_fill (r_sh_fill[k]),
      .o_hit  (w_hit[k])
    );
  end

  // Stage 1: register hit vector alongside the delayed video beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= '0;
      r_hit <= '0;
    end else begin
      r_s1  <= {de_in, hsync_in, vsync_in, pixel_in};
      r_hit <= w_hit;
    end
  end

  // Priority select: scanning downward leaves the lowest-index hit in place.
  always_comb begin
    w_any_hit   = 1'b0;
    w_sel_color = r_s1.pix;
    for (int k = NUM_BOXES - 1; k >= 0; k--) begin
      if (r_hit[k]) begin
        w_any_hit   = 1'b1;
        w_sel_color = r_sh_color[k];
      end
    end
  end

  // Stage 2: overlay colour only on active pixels once the overlay is live.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2 <= '0;
    end else begin
      r_s2 <= r_s1;
      if (r_s1.de && r_state == ST_ACTIVE && w_any_hit) r_s2.pix <= w_sel_color;
    end
  end

  assign de_out    = r_s2.de;
  assign hsync_out = r_s2.hsync;
  assign vsync_out = r_s2.vsync;
  assign pixel_out = r_s2.pix;

endmodule

// File: tb/tb_vis_multi_box_overlay.sv
// Bench for vis_multi_box_overlay: two instances (LINE_W=1 and LINE_W=3) share
// one stimulus stream; a geometric model predicts every output beat.
module tb_vis_multi_box_overlay;
  import vis_pkg::*;

  localparam int W = 64;
  localparam int H = 32;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, de_in, hsync_in, vsync_in;
  logic [23:0]       pixel_in;
  logic [11*N-1:0]   box_x0, box_y0, box_x1, box_y1;
  logic [24*N-1:0]   box_color;
  logic [N-1:0]      box_en, box_fill;
  logic              de_o1, hs_o1, vs_o1, de_o2, hs_o2, vs_o2;
  logic [23:0]       pix_o1, pix_o2;

  vis_multi_box_overlay #(.IMG_W(W), .IMG_H(H), .NUM_BOXES(N), .LINE_W(1)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_in(pixel_in), .box_x0(box_x0), .box_y0(box_y0), .box_x1(box_x1),
    .box_y1(box_y1), .box_color(box_color), .box_en(box_en), .box_fill(box_fill),
    .de_out(de_o1), .hsync_out(hs_o1), .vsync_out(vs_o1), .pixel_out(pix_o1));

  vis_multi_box_overlay #(.IMG_W(W), .IMG_H(H), .NUM_BOXES(N), .LINE_W(3)) dut3 (
    .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_in(pixel_in), .box_x0(box_x0), .box_y0(box_y0), .box_x1(box_x1),
    .box_y1(box_y1), .box_color(box_color), .box_en(box_en), .box_fill(box_fill),
    .de_out(de_o2), .hsync_out(hs_o2), .vsync_out(vs_o2), .pixel_out(pix_o2));

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q1[$];
  logic [26:0] exp_q2[$];

  int          m_x, m_y;
  bit          m_active, m_vs_q;
  int          sh_x0[N], sh_y0[N], sh_x1[N], sh_y1[N];
  logic [23:0] sh_col[N];
  bit          sh_en[N], sh_fill[N];

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Box k covers (x,y): inside a valid box, and either filled or within lw of a side.
  function automatic bit model_hit(int k, int lw, int x, int y);
    int d;
    if (!sh_en[k]) return 0;
    if (sh_x0[k] > sh_x1[k] || sh_y0[k] > sh_y1[k]) return 0;
    if (x < sh_x0[k] || x > sh_x1[k] || y < sh_y0[k] || y > sh_y1[k]) return 0;
    if (sh_fill[k]) return 1;
    d = min2(min2(x - sh_x0[k], sh_x1[k] - x), min2(y - sh_y0[k], sh_y1[k] - y));
    return d < lw;
  endfunction

  function automatic logic [23:0] model_pix(int lw, logic d, logic [23:0] p);
    if (!d || !m_active) return p;
    for (int k = 0; k < N; k++)
      if (model_hit(k, lw, m_x, m_y)) return sh_col[k];
    return p;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_active = 0; m_vs_q = 0;
    for (int k = 0; k < N; k++) begin
      sh_x0[k] = 0; sh_y0[k] = 0; sh_x1[k] = 0; sh_y1[k] = 0;
      sh_col[k] = '0; sh_en[k] = 0; sh_fill[k] = 0;
    end
  endtask

  task automatic model_edge(logic d, logic v);
    if (v && !m_vs_q) begin
      m_active = 1;
      for (int k = 0; k < N; k++) begin
        sh_x0[k]   = int'(box_x0[11*k +: 11]);
        sh_y0[k]   = int'(box_y0[11*k +: 11]);
        sh_x1[k]   = int'(box_x1[11*k +: 11]);
        sh_y1[k]   = int'(box_y1[11*k +: 11]);
        sh_col[k]  = box_color[24*k +: 24];
        sh_en[k]   = box_en[k];
        sh_fill[k] = box_fill[k];
      end
    end
    m_vs_q = v;
    if (v) begin
      m_x = 0; m_y = 0;
    end else if (d) begin
      m_x = m_x + 1;
      if (m_x == W) begin
        m_x = 0;
        m_y = (m_y == H - 1) ? 0 : m_y + 1;
      end
    end
  endtask

  task automatic check(string tag, logic [26:0] obs, logic [26:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [23:0] rand24();
    return 24'($urandom());
  endfunction

  task automatic step(input logic r, input logic d, input logic h, input logic v,
                      input logic [23:0] p);
    rst = r; de_in = d; hsync_in = h; vsync_in = v; pixel_in = p;
    if (r) begin
      model_reset();
    end else begin
      exp_q1.push_back({d, h, v, model_pix(1, d, p)});
      exp_q2.push_back({d, h, v, model_pix(3, d, p)});
      model_edge(d, v);
    end
    @(posedge clk); #1;
    if (r) begin
      check("reset_lw1", {de_o1, hs_o1, vs_o1, pix_o1}, 27'd0);
      check("reset_lw3", {de_o2, hs_o2, vs_o2, pix_o2}, 27'd0);
      exp_q1.delete(); exp_q1.push_back(27'd0);
      exp_q2.delete(); exp_q2.push_back(27'd0);
    end else begin
      check("out_lw1", {de_o1, hs_o1, vs_o1, pix_o1}, exp_q1.pop_front());
      check("out_lw3", {de_o2, hs_o2, vs_o2, pix_o2}, exp_q2.pop_front());
    end
    checks++;
    assert (dut.r_x <= 11'(W - 1)) else begin
      errors++;
      $error("FAIL x_bound observed=%0d expected<=%0d", dut.r_x, W - 1);
    end
  endtask

  task automatic set_box(int k, int x0, int y0, int x1, int y1, logic [23:0] col,
                         logic en, logic fill);
    box_x0[11*k +: 11] = 11'(x0);
    box_y0[11*k +: 11] = 11'(y0);
    box_x1[11*k +: 11] = 11'(x1);
    box_y1[11*k +: 11] = 11'(y1);
    box_color[24*k +: 24] = col;
    box_en[k] = en;
    box_fill[k] = fill;
  endtask

  // One frame: vsync pulse, then H lines of W pixels with random de gaps.
  // Optionally resets mid-line at rst_line, or moves box0's x0 at chg_line.
  task automatic run_frame(int rst_line, int chg_line, int new_x0);
    repeat (3) step(0, 0, 0, 1, rand24());
    repeat (2) step(0, 0, 0, 0, rand24());
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == chg_line && x == 0) box_x0[10:0] = 11'(new_x0);
        if (y == rst_line && x == W / 2) step(1, 1, 0, 0, rand24());
        if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) step(0, 0, 0, 0, rand24());
        step(0, 1, 0, 0, rand24());
      end
      step(0, 0, 1, 0, rand24());
      step(0, 0, 1, 0, rand24());
      step(0, 0, 0, 0, rand24());
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    box_x0 = '0; box_y0 = '0; box_x1 = '0; box_y1 = '0;
    box_color = '0; box_en = '0; box_fill = '0;
    repeat (3) step(1, 0, 0, 0, 24'd0);

    // Idle: pass-through before any frame start, even with a box enabled.
    set_box(0, 0, 0, 63, 31, RED, 1, 1);
    repeat (20) step(0, 1, 0, 0, rand24());

    // Outline box, lowest-index colour only.
    set_box(0, 10, 10, 20, 15, RED, 1, 0);
    run_frame(-1, -1, 0);

    // Overlapping filled boxes: box0 wins the overlap.
    set_box(0, 10, 10, 30, 20, GREEN, 1, 1);
    set_box(1, 20, 15, 40, 25, BLUE, 1, 1);
    run_frame(-1, -1, 0);

    // Mid-frame x0 change takes effect one frame later.
    set_box(0, 5, 5, 15, 12, RED, 1, 0);
    set_box(1, 0, 0, 0, 0, BLACK, 0, 0);
    run_frame(-1, 8, 25);
    run_frame(-1, -1, 0);

    // Degenerate box, origin box, box past the image edge, narrow outline box.
    set_box(0, 30, 5, 20, 10, WHITE, 1, 1);
    set_box(1, 0, 0, 5, 5, RED, 1, 0);
    set_box(2, 60, 28, 2000, 2000, GREEN, 1, 0);
    set_box(3, 40, 2, 43, 20, BLUE, 1, 0);
    run_frame(-1, -1, 0);

    // Reset mid-frame: pass-through for the rest, overlay back next frame.
    run_frame(5, -1, 0);
    run_frame(-1, -1, 0);

    // Random boxes and modes over two frames.
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < N; k++) begin
        int x0, y0;
        x0 = $urandom_range(0, 70);
        y0 = $urandom_range(0, 36);
        set_box(k, x0, y0, x0 + $urandom_range(0, 20) - 2, y0 + $urandom_range(0, 12) - 2,
                rand24(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      run_frame(-1, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
